// File: rtl/simon_led_sequencer.sv
// LED driver for the Simon game: timed playback of a colour sequence, button
// mirroring while the player answers, and a pass/fail flash with a done pulse.
module simon_led_sequencer #(
  parameter int NUM_LEDS     = 4,
  parameter int SEQ_DEPTH    = 8,
  parameter int ON_CYCLES    = 25,
  parameter int OFF_CYCLES   = 10,
  parameter int FLASH_CYCLES = 20,
  parameter int FLASH_COUNT  = 3,
  localparam int IDXW = $clog2(NUM_LEDS),
  localparam int LW   = $clog2(SEQ_DEPTH + 1)
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic [1:0]                mode_i,
  input  logic                      start_i,
  input  logic [SEQ_DEPTH*IDXW-1:0] seq_data_i,
  input  logic [LW-1:0]             seq_len_i,
  input  logic [NUM_LEDS-1:0]       buttons_i,
  input  logic                      result_ok_i,
  output logic [NUM_LEDS-1:0]       leds_o,
  output logic                      busy_o,
  output logic                      display_done_o,
  output logic [LW-1:0]             step_index_o
);

  localparam int MAX_ONOFF = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int MAX_PHASE = (MAX_ONOFF > FLASH_CYCLES) ? MAX_ONOFF : FLASH_CYCLES;
  localparam int CW = $clog2(MAX_PHASE + 1);
  localparam int FW = $clog2(FLASH_COUNT) + 1;

  localparam logic [CW-1:0] ON_LOAD    = CW'(ON_CYCLES - 1);
  localparam logic [CW-1:0] OFF_LOAD   = CW'(OFF_CYCLES - 1);
  localparam logic [CW-1:0] FLASH_LOAD = CW'(FLASH_CYCLES - 1);
  localparam logic [FW-1:0] FCNT_LOAD  = FW'(FLASH_COUNT - 1);
  localparam logic [LW-1:0] DEPTH_LW   = LW'(SEQ_DEPTH);

  localparam logic [1:0] MODE_IDLE    = 2'b00;
  localparam logic [1:0] MODE_DISPLAY = 2'b01;
  localparam logic [1:0] MODE_INPUT   = 2'b10;
  localparam logic [1:0] MODE_RESULT  = 2'b11;

  function automatic logic [NUM_LEDS-1:0] alt_pattern();
    logic [NUM_LEDS-1:0] r;
    for (int i = 0; i < NUM_LEDS; i++) r[i] = ((i % 2) == 0);
    return r;
  endfunction

  localparam logic [NUM_LEDS-1:0] FAIL_PAT = alt_pattern();

  // state       | meaning
  // S_IDLE      | leds follow mode (all on / buttons / dark); waits for start
  // S_ON        | current step's colour lit
  // S_OFF       | dark gap after a step
  // S_FLASH_ON  | result pattern lit
  // S_FLASH_OFF | result pattern dark
  // S_DONE      | one-cycle completion pulse
  typedef enum logic [2:0] {
    S_IDLE, S_ON, S_OFF, S_FLASH_ON, S_FLASH_OFF, S_DONE
  } state_t;

  state_t                    state_q, state_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [LW-1:0]             k_q, k_d;
  logic [LW-1:0]             len_q, len_d;
  logic [FW-1:0]             fcnt_q, fcnt_d;
  logic [SEQ_DEPTH*IDXW-1:0] seq_q, seq_d;
  logic                      ok_q, ok_d;
  logic [NUM_LEDS-1:0]       leds_q, leds_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic [LW-1:0]             step_q, step_d;

  logic [IDXW-1:0]     colour;
  logic [NUM_LEDS-1:0] step_leds;
  logic [NUM_LEDS-1:0] idle_leds;
  logic [LW-1:0]       len_clamped;

  always_comb begin
    colour = '0;
    for (int i = 0; i < SEQ_DEPTH; i++) begin
      if (k_q == LW'(i)) colour = seq_q[i*IDXW +: IDXW];
    end
  end

  // Colour codes beyond the channel count never match, leaving the LEDs dark.
  always_comb begin
    step_leds = '0;
    for (int i = 0; i < NUM_LEDS; i++) step_leds[i] = (colour == IDXW'(i));
  end

  always_comb begin
    case (mode_i)
      MODE_IDLE:  idle_leds = '1;
      MODE_INPUT: idle_leds = buttons_i;
      default:    idle_leds = '0;
    endcase
  end

  assign len_clamped = (seq_len_i > DEPTH_LW) ? DEPTH_LW : seq_len_i;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    len_d   = len_q;
    fcnt_d  = fcnt_q;
    seq_d   = seq_q;
    ok_d    = ok_q;
    leds_d  = '0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    step_d  = '0;

    case (state_q)
      S_IDLE: begin
        leds_d = idle_leds;
        if (start_i && mode_i == MODE_DISPLAY) begin
          seq_d = seq_data_i;
          len_d = len_clamped;
          k_d   = '0;
          cnt_d = ON_LOAD;
          state_d = (len_clamped == '0) ? S_DONE : S_ON;
        end else if (start_i && mode_i == MODE_RESULT) begin
          ok_d    = result_ok_i;
          fcnt_d  = FCNT_LOAD;
          cnt_d   = FLASH_LOAD;
          state_d = S_FLASH_ON;
        end
      end

      S_ON, S_OFF: begin
        if (mode_i != MODE_DISPLAY) begin
          // Abort shows the new mode's idle LEDs on the same edge.
          leds_d  = idle_leds;
          state_d = S_IDLE;
        end else begin
          busy_d = 1'b1;
          step_d = k_q;
          leds_d = (state_q == S_ON) ? step_leds : '0;
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
          end else if (state_q == S_ON) begin
            cnt_d   = OFF_LOAD;
            state_d = S_OFF;
          end else if (k_q + LW'(1) < len_q) begin
            k_d     = k_q + LW'(1);
            cnt_d   = ON_LOAD;
            state_d = S_ON;
          end else begin
            state_d = S_DONE;
          end
        end
      end

      S_FLASH_ON, S_FLASH_OFF: begin
        if (mode_i != MODE_RESULT) begin
          leds_d  = idle_leds;
          state_d = S_IDLE;
        end else begin
          busy_d = 1'b1;
          if (state_q == S_FLASH_ON) leds_d = ok_q ? '1 : FAIL_PAT;
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
          end else if (state_q == S_FLASH_ON) begin
            cnt_d   = FLASH_LOAD;
            state_d = S_FLASH_OFF;
          end else if (fcnt_q != '0) begin
            fcnt_d  = fcnt_q - FW'(1);
            cnt_d   = FLASH_LOAD;
            state_d = S_FLASH_ON;
          end else begin
            state_d = S_DONE;
          end
        end
      end

      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      k_q     <= '0;
      len_q   <= '0;
      fcnt_q  <= '0;
      seq_q   <= '0;
      ok_q    <= 1'b0;
      leds_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
      len_q   <= len_d;
      fcnt_q  <= fcnt_d;
      seq_q   <= seq_d;
      ok_q    <= ok_d;
      leds_q  <= leds_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      step_q  <= step_d;
    end
  end

  assign leds_o         = leds_q;
  assign busy_o         = busy_q;
  assign display_done_o = done_q;
  assign step_index_o   = step_q;

endmodule
